// File: rtl/tsc_pkg.sv
// rtl/tsc_pkg.sv - shared state encoding, width helpers and defaults for tsc_trig_capture
package tsc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_POST,
        ST_HOLD,
        ST_SEND
    } state_t;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_PRE_TRIG = 4;
    localparam int DEF_TS_W     = 32;
    localparam int DEF_NUM_TRIG = 4;

    // $clog2 that never returns zero, so single-entry fields still get one bit
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int chan_w(input int num_trig);
        return clog2_min1(num_trig);
    endfunction

    function automatic int ptr_w(input int depth);
        return clog2_min1(depth);
    endfunction

    // Fill counter must be able to hold the value DEPTH itself
    function automatic int fill_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/tsc_trig_capture_if.sv
// rtl/tsc_trig_capture_if.sv - readout stream handshake between capture block and host path
interface tsc_trig_capture_if
    import tsc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) ();

    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic              rd_last;

    modport master (
        output rd_data,
        output rd_valid,
        output rd_last,
        input  rd_ready
    );

    modport slave (
        input  rd_data,
        input  rd_valid,
        input  rd_last,
        output rd_ready
    );

endinterface

// File: rtl/tsc_ring_mem.sv
// rtl/tsc_ring_mem.sv - DEPTH x DATA_W sample store, synchronous write, asynchronous read
module tsc_ring_mem
    import tsc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int AW    = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tsc_trig_capture.sv
// rtl/tsc_trig_capture.sv - pre/post-trigger ring capture with timestamped trigger and streamed readout
module tsc_trig_capture
    import tsc_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int PRE_TRIG = DEF_PRE_TRIG,
    parameter int TS_W     = DEF_TS_W,
    parameter int NUM_TRIG = DEF_NUM_TRIG
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        send_buf,
    input  logic [DATA_W-1:0]           data,
    input  logic [NUM_TRIG-1:0]         trig,
    input  logic [NUM_TRIG-1:0]         trig_mask,
    tsc_trig_capture_if.master          rd,
    output logic                        complete,
    output logic [TS_W-1:0]             trig_time,
    output logic [chan_w(NUM_TRIG)-1:0] trig_chan,
    output logic                        triggered,
    output logic                        armed,
    output logic                        ready
);

    localparam int AW        = ptr_w(DEPTH);
    localparam int FW        = fill_w(DEPTH);
    localparam int CW        = chan_w(NUM_TRIG);
    localparam int POST_LOAD = DEPTH - PRE_TRIG - 1;

    state_t              state;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       rd_cnt;
    logic [AW-1:0]       post;
    logic [FW-1:0]       fill;
    logic [TS_W-1:0]     timer;
    logic [NUM_TRIG-1:0] trig_q;
    logic [NUM_TRIG-1:0] trig_edge;
    logic [CW-1:0]       edge_chan;
    logic                sampling;
    logic                go_run;
    logic                xfer;

    assign sampling  = (state == ST_RUN) || (state == ST_POST);
    assign go_run    = start && ((state == ST_IDLE) || (state == ST_HOLD));
    assign xfer      = rd.rd_valid && rd.rd_ready;
    assign trig_edge = trig & ~trig_q & trig_mask;
    assign armed     = (state == ST_RUN) && (fill >= FW'(PRE_TRIG));

    // Lowest-numbered channel wins when several lines rise together
    always_comb begin
        edge_chan = '0;
        for (int i = NUM_TRIG - 1; i >= 0; i--) begin
            if (trig_edge[i]) begin
                edge_chan = CW'(i);
            end
        end
    end

    tsc_ring_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk    (clk),
        .we     (sampling),
        .waddr  (wr_ptr),
        .wdata  (data),
        .raddr  (rd_ptr),
        .rdata  (rd.rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            ready       <= 1'b1;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rd_cnt      <= '0;
            post        <= '0;
            fill        <= '0;
            timer       <= '0;
            trig_q      <= '0;
            rd.rd_valid <= 1'b0;
            rd.rd_last  <= 1'b0;
            complete    <= 1'b0;
            triggered   <= 1'b0;
            trig_time   <= '0;
            trig_chan   <= '0;
        end else begin
            trig_q   <= trig;
            complete <= 1'b0;

            if (sampling) begin
                wr_ptr <= wr_ptr + AW'(1);
                timer  <= timer + TS_W'(1);
                if (fill != FW'(DEPTH)) begin
                    fill <= fill + FW'(1);
                end
            end

            // start outranks send_buf in HOLD
            if (go_run) begin
                state     <= ST_RUN;
                ready     <= 1'b0;
                timer     <= '0;
                wr_ptr    <= '0;
                fill      <= '0;
                triggered <= 1'b0;
            end else begin
                case (state)
                    ST_RUN: begin
                        if (armed && (|trig_edge)) begin
                            trig_time <= timer;
                            trig_chan <= edge_chan;
                            triggered <= 1'b1;
                            post      <= AW'(POST_LOAD);
                            // With PRE_TRIG = DEPTH-1 the trigger sample is also the last one
                            if (POST_LOAD == 0) begin
                                state <= ST_HOLD;
                                ready <= 1'b1;
                            end else begin
                                state <= ST_POST;
                            end
                        end
                    end
                    ST_POST: begin
                        post <= post - AW'(1);
                        if (post == AW'(1)) begin
                            state <= ST_HOLD;
                            ready <= 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (send_buf) begin
                            state       <= ST_SEND;
                            ready       <= 1'b0;
                            rd_ptr      <= wr_ptr;
                            rd_cnt      <= '0;
                            rd.rd_valid <= 1'b1;
                            rd.rd_last  <= 1'b0;
                        end
                    end
                    ST_SEND: begin
                        if (xfer) begin
                            rd_ptr     <= rd_ptr + AW'(1);
                            rd_cnt     <= rd_cnt + AW'(1);
                            rd.rd_last <= (rd_cnt == AW'(DEPTH - 2));
                            if (rd.rd_last) begin
                                rd.rd_valid <= 1'b0;
                                rd.rd_last  <= 1'b0;
                                complete    <= 1'b1;
                                state       <= ST_HOLD;
                                ready       <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tsc_trig_capture.sv
// tb/tb_tsc_trig_capture.sv - self-checking bench for tsc_trig_capture
module tb_tsc_trig_capture;
    import tsc_pkg::*;

    localparam int DEPTH = 16;
    localparam int PRE   = 4;

    logic       clk = 1'b0;
    logic       reset, start, send_buf, rd_ready;
    logic [7:0] data;
    logic [3:0] trig, trig_mask;

    logic        complete_a, triggered_a, armed_a, ready_a;
    logic [31:0] trig_time_a;
    logic [1:0]  trig_chan_a;
    logic        complete_b, triggered_b, armed_b, ready_b;
    logic [3:0]  trig_time_b;
    logic [1:0]  trig_chan_b;

    tsc_trig_capture_if #(.DATA_W(8)) rda ();
    tsc_trig_capture_if #(.DATA_W(8)) rdb ();

    assign rda.rd_ready = rd_ready;
    assign rdb.rd_ready = rd_ready;

    always #5 clk = ~clk;

    tsc_trig_capture #(.DATA_W(8), .DEPTH(DEPTH), .PRE_TRIG(PRE), .TS_W(32), .NUM_TRIG(4)) dut_a (
        .clk(clk), .reset(reset), .start(start), .send_buf(send_buf), .data(data),
        .trig(trig), .trig_mask(trig_mask), .rd(rda.master), .complete(complete_a),
        .trig_time(trig_time_a), .trig_chan(trig_chan_a), .triggered(triggered_a),
        .armed(armed_a), .ready(ready_a)
    );

    tsc_trig_capture #(.DATA_W(8), .DEPTH(DEPTH), .PRE_TRIG(PRE), .TS_W(4), .NUM_TRIG(4)) dut_b (
        .clk(clk), .reset(reset), .start(start), .send_buf(send_buf), .data(data),
        .trig(trig), .trig_mask(trig_mask), .rd(rdb.master), .complete(complete_b),
        .trig_time(trig_time_b), .trig_chan(trig_chan_b), .triggered(triggered_b),
        .armed(armed_b), .ready(ready_b)
    );

    typedef struct {
        string           name;
        logic [3:0]      mask;
        logic [3:0]      init;
        int              n_ev;
        logic [3:0][7:0] ev_t;
        logic [3:0][3:0] ev_v;
        int              exp_t;
        int              exp_c;
        bit              bp;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] exp_q [$];
    int         n_cmp = 0;
    int         n_bad = 0;

    function automatic vec_t mk(string n, logic [3:0] m, logic [3:0] i, int ne,
                                logic [31:0] t, logic [15:0] v, int et, int ec, bit bp);
        vec_t r;
        r.name = n; r.mask = m; r.init = i; r.n_ev = ne;
        r.ev_t = t; r.ev_v = v; r.exp_t = et; r.exp_c = ec; r.bp = bp;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_window(input int t);
        for (int j = t - PRE; j < t + DEPTH - PRE; j++) exp_q.push_back(8'(j));
    endtask

    task automatic run_vec(input vec_t v);
        int k, hold_t;
        trig_mask = v.mask;
        trig      = v.init;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check({v.name, "_run_ready"}, ready_a, 1'b0);
        check({v.name, "_run_trig"}, triggered_a, 1'b0);
        k      = 0;
        hold_t = -1;
        for (int tt = 0; tt < 80; tt++) begin
            data = 8'(tt);
            if (k < v.n_ev && tt == int'(v.ev_t[k])) begin
                trig = v.ev_v[k];
                k++;
            end
            if (tt == v.exp_t) push_window(tt);
            if (tt <= v.exp_t) check({v.name, "_armed"}, armed_a, (tt >= PRE));
            tick();
            if (ready_a) begin
                hold_t = tt;
                break;
            end
        end
        check({v.name, "_hold_at"}, 64'(hold_t), 64'(v.exp_t + DEPTH - PRE - 1));
        check({v.name, "_triggered"}, triggered_a, 1'b1);
        check({v.name, "_trig_time"}, trig_time_a, 64'(v.exp_t));
        check({v.name, "_trig_chan"}, trig_chan_a, 64'(v.exp_c));
        check({v.name, "_trig_time_w4"}, trig_time_b, 64'(v.exp_t % 16));
        check({v.name, "_hold_armed"}, armed_a, 1'b0);
    endtask

    task automatic readout(input string name, input bit bp);
        int         got, ncomp;
        bit         stalled;
        logic [7:0] held, e;
        got = 0; ncomp = 0; stalled = 0; held = '0;
        send_buf = 1'b1;
        tick();
        send_buf = 1'b0;
        check({name, "_first_valid"}, rda.rd_valid, 1'b1);
        for (int c = 0; c < 300 && got < DEPTH; c++) begin
            rd_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (complete_a) ncomp++;
            if (rda.rd_valid) begin
                if (stalled) check({name, "_stable"}, rda.rd_data, held);
                if (rd_ready) begin
                    if (exp_q.size() == 0) begin
                        check({name, "_extra_word"}, 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check({name, "_data"}, rda.rd_data, e);
                        check({name, "_last"}, rda.rd_last, (exp_q.size() == 0));
                    end
                    got++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held    = rda.rd_data;
                end
            end
            tick();
        end
        rd_ready = 1'b0;
        check({name, "_count"}, 64'(got), 64'(DEPTH));
        check({name, "_early_complete"}, 64'(ncomp), 64'(0));
        check({name, "_complete"}, complete_a, 1'b1);
        check({name, "_valid_after"}, rda.rd_valid, 1'b0);
        check({name, "_ready_after"}, ready_a, 1'b1);
        tick();
        check({name, "_complete_once"}, complete_a, 1'b0);
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = mk("basic",    4'hF, 4'h0, 1, 32'h0000000A, 16'h0004, 10, 2, 1'b0);
        vecs[1] = mk("arming",   4'h7, 4'h0, 4, 32'h07060502, 16'hA8A2,  7, 1, 1'b1);
        vecs[2] = mk("priority", 4'hF, 4'h1, 2, 32'h00000803, 16'h0090,  8, 0, 1'b0);
        vecs[3] = mk("arm_edge", 4'hF, 4'h0, 1, 32'h00000004, 16'h0008,  4, 3, 1'b0);
        vecs[4] = mk("drop3",    4'hF, 4'h0, 3, 32'h00050403, 16'h0101,  5, 0, 1'b1);
        vecs[5] = mk("wrap",     4'hF, 4'h0, 1, 32'h00000011, 16'h0004, 17, 2, 1'b0);

        reset = 1'b1; start = 1'b0; send_buf = 1'b0; rd_ready = 1'b0;
        data = '0; trig = '0; trig_mask = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_ready", ready_a, 1'b1);
        check("rst_valid", rda.rd_valid, 1'b0);
        check("rst_last", rda.rd_last, 1'b0);
        check("rst_complete", complete_a, 1'b0);
        check("rst_trig_time", trig_time_a, 64'd0);
        check("rst_trig_chan", trig_chan_a, 64'd0);
        check("rst_triggered", triggered_a, 1'b0);
        check("rst_armed", armed_a, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
            readout(vecs[i].name, vecs[i].bp);
            if (i == 1) begin
                push_window(vecs[i].exp_t);
                readout("replay", 1'b1);
            end
        end

        // start and send_buf together in HOLD: start wins
        start = 1'b1; send_buf = 1'b1;
        tick();
        start = 1'b0; send_buf = 1'b0;
        check("prio_ready", ready_a, 1'b0);
        check("prio_triggered", triggered_a, 1'b0);
        check("prio_valid", rda.rd_valid, 1'b0);
        tick();
        check("prio_valid2", rda.rd_valid, 1'b0);
        check("prio_armed", armed_a, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // reset in the middle of a readout
        run_vec(vecs[0]);
        send_buf = 1'b1;
        tick();
        send_buf = 1'b0;
        rd_ready = 1'b1;
        tick(); tick(); tick();
        check("midsend_valid_pre", rda.rd_valid, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd_ready = 1'b0;
        check("midsend_valid", rda.rd_valid, 1'b0);
        check("midsend_ready", ready_a, 1'b1);
        check("midsend_triggered", triggered_a, 1'b0);
        check("midsend_last", rda.rd_last, 1'b0);
        check("midsend_complete", complete_a, 1'b0);
        exp_q.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
